id_ex_shift_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage CPU, placed directly upstream of the EX-stage ALU/shifter.
- Resolves operand forwarding from EX/MEM and MEM/WB, and maps shift funct codes onto the shifter's dataA/dataB/Signal convention.
- Detects load-use hazards and inserts bubbles.
- All EX-facing outputs are registered, so the shifter sees stable operands for the full EX cycle.

---
 rtl/id_ex_shift_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_shift_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register feeding the EX-stage shifter/ALU.
// Resolves operand forwarding, maps shift funct codes onto the shifter's
// dataA/dataB/Signal convention, and inserts bubbles on data hazards.
// Optional feature macro: ID_EX_FWD_EN
//   defined   -> EX/MEM and MEM/WB results are forwarded into the operands;
//                only load-use hazards stall.
//   undefined -> operands come straight from the register file; any RAW
//                hit against EX or EX/MEM also stalls (MEM/WB is covered by
//                the write-first register file).
module id_ex_shift_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [REG_AW-1:0]  id_shamt,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               exmem_reg_write,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REG_AW-1:0]  memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_dataA,
  output logic [DATA_W-1:0]  ex_dataB,
  output logic [FUNCT_W-1:0] ex_signal,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               hazard_stall
);

  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_SRA  = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] F_SLLV = FUNCT_W'(6'b000100);
  localparam logic [FUNCT_W-1:0] F_SRLV = FUNCT_W'(6'b000110);
  localparam logic [FUNCT_W-1:0] F_SRAV = FUNCT_W'(6'b000111);

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] data_a_next;
  logic [DATA_W-1:0] data_b_next;
  logic              ex_src_match;
  logic              load_use;
  logic              raw_stall;

  // EX-stage destination matches either ID source index.
  assign ex_src_match = (ex_rd == id_rs) || (ex_rd == id_rt);

  // A load in EX cannot supply its data in time for a dependent instruction.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && ex_src_match;

`ifdef ID_EX_FWD_EN
  // Forwarding mux per source: EX/MEM beats MEM/WB, r0 is never forwarded.
  always_comb begin
    rs_fwd = id_rs_data;
    rt_fwd = id_rt_data;
    if (exmem_reg_write && (exmem_rd == id_rs) && (id_rs != '0))
      rs_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd == id_rs) && (id_rs != '0))
      rs_fwd = memwb_result;
    if (exmem_reg_write && (exmem_rd == id_rt) && (id_rt != '0))
      rt_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd == id_rt) && (id_rt != '0))
      rt_fwd = memwb_result;
  end

  assign raw_stall = 1'b0;
`else
  logic raw_ex;
  logic raw_exmem;
  logic unused_fwd_inputs;

  assign rs_fwd = id_rs_data;
  assign rt_fwd = id_rt_data;

  // Without forwarding, any in-flight producer in EX or EX/MEM must drain first.
  assign raw_ex    = ex_valid && ex_reg_write && (ex_rd != '0) && id_valid && ex_src_match;
  assign raw_exmem = exmem_reg_write && (exmem_rd != '0) && id_valid &&
                     ((exmem_rd == id_rs) || (exmem_rd == id_rt));
  assign raw_stall = raw_ex || raw_exmem;

  // Forwarding sources are not consumed in this build.
  assign unused_fwd_inputs = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  assign hazard_stall = load_use || raw_stall;

  // Map the funct code onto the shifter operand convention.
  always_comb begin
    data_a_next = rs_fwd;
    data_b_next = rt_fwd;
    case (id_funct)
      F_SLL, F_SRL, F_SRA: begin
        data_a_next = rt_fwd;
        data_b_next = {{(DATA_W-REG_AW){1'b0}}, id_shamt};
      end
      F_SLLV, F_SRLV, F_SRAV: begin
        // Full-width amount; the shifter itself zeroes results for amounts >= 32.
        data_a_next = rt_fwd;
        data_b_next = rs_fwd;
      end
      default: ;
    endcase
  end

  // Pipeline register: flush > hold > bubble > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_dataA     <= '0;
      ex_dataB     <= '0;
      ex_signal    <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (stall_in) begin
      // Hold: downstream is not ready to accept a new EX instruction.
    end else if (hazard_stall) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_dataA     <= data_a_next;
      ex_dataB     <= data_b_next;
      ex_signal    <= id_funct;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write && id_valid;
      ex_mem_read  <= id_mem_read && id_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Self-checking bench for id_ex_shift_stage: scenario tasks push expected
// EX outputs into a scoreboard queue when ID is driven and pop/compare them
// one cycle later. Forwarding-specific scenarios follow ID_EX_FWD_EN.
module tb_id_ex_shift_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data, id_rt_data;
  logic        id_reg_write, id_mem_read;
  logic        stall_in, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] ex_dataA, ex_dataB;
  logic [5:0]  ex_signal;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic        hazard_stall;

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t exp_q[$];
  out_t e, a, last;

  id_ex_shift_stage #(.DATA_W(32), .REG_AW(5), .FUNCT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall_in(stall_in), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_dataA(ex_dataA), .ex_dataB(ex_dataB),
    .ex_signal(ex_signal), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic out_t cur_out();
    return {ex_valid, ex_dataA, ex_dataB, ex_signal, ex_rd, ex_reg_write, ex_mem_read};
  endfunction

  // Expected EX contents for an instruction with no forwarding involved.
  function automatic out_t exp_map(input logic v, input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rsd, input logic [31:0] rtd,
                                   input logic [4:0] rd, input logic rw, input logic mr);
    out_t r;
    r.valid = v; r.sig = f; r.rd = rd; r.rw = rw & v; r.mr = mr & v;
    if (f == 6'd0 || f == 6'd2 || f == 6'd3) begin
      r.a = rtd; r.b = {27'd0, sh};
    end else if (f == 6'd4 || f == 6'd6 || f == 6'd7) begin
      r.a = rtd; r.b = rsd;
    end else begin
      r.a = rsd; r.b = rtd;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] f,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh; id_funct = f;
    id_rs_data = rsd; id_rt_data = rtd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle_inputs();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    stall_in = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  // Drain EX to an invalid, non-writing state between scenarios.
  task automatic settle();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 5'd9, 6'h22, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    tick();
    #3 rst_n = 1'b0;
    #1;
    a = cur_out();
    n_checks++;
    if (a !== '0) $display("FAIL reset_async_outputs: got %h want 0", a);
    else n_pass++;
    n_checks++;
    if (hazard_stall !== 1'b0) $display("FAIL reset_hazard: got %b want 0", hazard_stall);
    else n_pass++;
    #1 rst_n = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100000, 32'd5, 32'd7, 1'b1, 1'b0);
    e = '{valid: 1'b1, a: 32'd5, b: 32'd7, sig: 6'b100000, rd: 5'd9, rw: 1'b1, mr: 1'b0};
    exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL reset_first_load: got %h want %h", a, e);
    else n_pass++;
    $display("test_reset: done");
  endtask

  task automatic test_srl_mapping();
    settle();
    drive_id(1'b1, 5'd11, 5'd12, 5'd13, 5'd4, 6'b000010, 32'h0000_0055, 32'hF000_0000, 1'b1, 1'b0);
    e = '{valid: 1'b1, a: 32'hF000_0000, b: 32'd4, sig: 6'b000010, rd: 5'd13, rw: 1'b1, mr: 1'b0};
    exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL srl_mapping: got %h want %h", a, e);
    else n_pass++;
    $display("test_srl_mapping: dataA=%h dataB=%h signal=%b", ex_dataA, ex_dataB, ex_signal);
  endtask

`ifdef ID_EX_FWD_EN
  task automatic test_forward_priority();
    settle();
    drive_id(1'b1, 5'd4, 5'd3, 5'd6, 5'd1, 6'b000010, 32'h0000_AAAA, 32'h0000_3333, 1'b1, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    exp_q.push_back('{valid: 1'b1, a: 32'h11, b: 32'd1, sig: 6'b000010, rd: 5'd6, rw: 1'b1, mr: 1'b0});
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL fwd_exmem_priority: got %h want %h", a, e);
    else n_pass++;
    exmem_reg_write = 1'b0;
    exp_q.push_back('{valid: 1'b1, a: 32'h22, b: 32'd1, sig: 6'b000010, rd: 5'd6, rw: 1'b1, mr: 1'b0});
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL fwd_memwb: got %h want %h", a, e);
    else n_pass++;
    id_rt = 5'd0; exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    exp_q.push_back('{valid: 1'b1, a: 32'h3333, b: 32'd1, sig: 6'b000010, rd: 5'd6, rw: 1'b1, mr: 1'b0});
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL fwd_r0_never: got %h want %h", a, e);
    else n_pass++;
    $display("test_forward_priority: done");
  endtask
`else
  task automatic test_forward_priority();
    // No forwarding: MEM/WB hit neither stalls nor replaces register-file data.
    settle();
    drive_id(1'b1, 5'd4, 5'd3, 5'd6, 5'd1, 6'b000010, 32'h0000_AAAA, 32'h0000_3333, 1'b1, 1'b0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) $display("FAIL memwb_no_stall: got %b want 0", hazard_stall);
    else n_pass++;
    exp_q.push_back('{valid: 1'b1, a: 32'h3333, b: 32'd1, sig: 6'b000010, rd: 5'd6, rw: 1'b1, mr: 1'b0});
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL memwb_rf_data: got %h want %h", a, e);
    else n_pass++;
    $display("test_forward_priority: no-forward build, register-file data used");
  endtask

  task automatic test_nofwd_hazard();
    settle();
    drive_id(1'b1, 5'd6, 5'd5, 5'd12, 5'd0, 6'h20, 32'h60, 32'h50, 1'b1, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h99;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) $display("FAIL nofwd_exmem_stall: got %b want 1", hazard_stall);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000 || hazard_stall !== 1'b1)
        $display("FAIL nofwd_bubble_%0d: got v/rw/mr=%b%b%b hz=%b want 000 hz=1",
                 i, ex_valid, ex_reg_write, ex_mem_read, hazard_stall);
      else n_pass++;
    end
    exmem_reg_write = 1'b0;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) $display("FAIL nofwd_retired: got %b want 0", hazard_stall);
    else n_pass++;
    exp_q.push_back(exp_map(1'b1, 6'h20, 5'd0, 32'h60, 32'h50, 5'd12, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL nofwd_reload: got %h want %h", a, e);
    else n_pass++;
    $display("test_nofwd_hazard: done");
  endtask
`endif

  task automatic test_load_use();
    settle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20, 32'h1000, 32'h4, 1'b1, 1'b1);
    exp_q.push_back(exp_map(1'b1, 6'h20, 5'd0, 32'h1000, 32'h4, 5'd8, 1'b1, 1'b1));
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL lw_in_ex: got %h want %h", a, e);
    else n_pass++;
    // SRLV with rs=8: amount 0x25 (>= 32) must pass through unmasked.
    drive_id(1'b1, 5'd8, 5'd9, 5'd10, 5'd0, 6'b000110, 32'h25, 32'h8000_0000, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) $display("FAIL load_use_detect: got %b want 1", hazard_stall);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000)
      $display("FAIL load_use_bubble: got v/rw/mr=%b%b%b want 000", ex_valid, ex_reg_write, ex_mem_read);
    else n_pass++;
    n_checks++;
    if (hazard_stall !== 1'b0) $display("FAIL load_use_clear: got %b want 0", hazard_stall);
    else n_pass++;
    exp_q.push_back('{valid: 1'b1, a: 32'h8000_0000, b: 32'h25, sig: 6'b000110, rd: 5'd10, rw: 1'b1, mr: 1'b0});
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL load_use_reload: got %h want %h", a, e);
    else n_pass++;
    // A load to r0 never stalls its consumer.
    settle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20, 32'h1, 32'h2, 1'b0, 1'b1);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20, 32'h1, 32'h2, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) $display("FAIL load_r0_no_stall: got %b want 0", hazard_stall);
    else n_pass++;
    $display("test_load_use: done");
  endtask

  task automatic test_stall_flush();
    settle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd17, 5'd0, 6'h22, 32'h100, 32'h200, 1'b1, 1'b0);
    exp_q.push_back(exp_map(1'b1, 6'h22, 5'd0, 32'h100, 32'h200, 5'd17, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); a = cur_out();
    n_checks++;
    if (a !== e) $display("FAIL stall_preload: got %h want %h", a, e);
    else n_pass++;
    last = e;
    for (int i = 0; i < 3; i++) begin
      stall_in = 1'b1;
      drive_id(1'b1, 5'($urandom_range(1, 15)), 5'($urandom_range(1, 15)),
               5'($urandom_range(16, 31)), 5'($urandom), 6'($urandom),
               $urandom, $urandom, 1'b0, 1'b1);
      tick();
      a = cur_out();
      n_checks++;
      if (a !== last) $display("FAIL stall_hold_%0d: got %h want %h", i, a, last);
      else n_pass++;
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000)
      $display("FAIL flush_over_stall: got v/rw/mr=%b%b%b want 000", ex_valid, ex_reg_write, ex_mem_read);
    else n_pass++;
    // Hazard while downstream holds: no bubble replaces the held load.
    settle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20, 32'h40, 32'h8, 1'b1, 1'b1);
    tick();
    last = exp_map(1'b1, 6'h20, 5'd0, 32'h40, 32'h8, 5'd8, 1'b1, 1'b1);
    drive_id(1'b1, 5'd8, 5'd9, 5'd10, 5'd0, 6'b000110, 32'h3, 32'h77, 1'b1, 1'b0);
    stall_in = 1'b1;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) $display("FAIL stall_hazard_detect: got %b want 1", hazard_stall);
    else n_pass++;
    tick();
    a = cur_out();
    n_checks++;
    if (a !== last) $display("FAIL hazard_under_stall_hold: got %h want %h", a, last);
    else n_pass++;
    // Reset while stalled clears immediately.
    #3 rst_n = 1'b0;
    #1;
    a = cur_out();
    n_checks++;
    if (a !== '0) $display("FAIL reset_mid_stall: got %h want 0", a);
    else n_pass++;
    rst_n = 1'b1;
    stall_in = 1'b0;
    $display("test_stall_flush: done");
  endtask

  task automatic test_back_to_back();
    logic [5:0] fset [8];
    fset = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'h20, 6'h22};
    settle();
    for (int i = 0; i < 10; i++) begin
      logic        v, rw;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  f;
      logic [31:0] rsd, rtd;
      v = 1'($urandom); rw = 1'($urandom);
      rs = 5'($urandom_range(1, 15)); rt = 5'($urandom_range(1, 15));
      rd = 5'($urandom_range(16, 31)); sh = 5'($urandom);
      f = fset[$urandom_range(0, 7)];
      rsd = $urandom; rtd = $urandom;
      drive_id(v, rs, rt, rd, sh, f, rsd, rtd, rw, 1'b0);
      exp_q.push_back(exp_map(v, f, sh, rsd, rtd, rd, rw, 1'b0));
      tick();
      e = exp_q.pop_front(); a = cur_out();
      n_checks++;
      if (a !== e) $display("FAIL b2b_%0d: got %h want %h", i, a, e);
      else n_pass++;
      $display("b2b %0d: funct=%b valid=%b dataA=%h dataB=%h", i, f, ex_valid, ex_dataA, ex_dataB);
    end
  endtask

  initial begin
    test_reset();
    test_srl_mapping();
    test_forward_priority();
`ifndef ID_EX_FWD_EN
    test_nofwd_hazard();
`endif
    test_load_use();
    test_stall_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
